// File: rtl/speck_key_sched_ctrl.sv
// rtl/speck_key_sched_ctrl.sv - Speck key-expansion sequencer: drives an external step unit, buffers round keys, streams them out
module speck_key_sched_ctrl #(
    parameter int ROUNDS  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         mode,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic         ks_start,
    output logic [127:0] ks_key,
    output logic [63:0]  ks_round,
    input  logic         ks_finished,
    input  logic [127:0] ks_out_key,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [63:0]  rk_data,
    output logic [4:0]   rk_index,
    output logic         rk_last
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [4:0] LAST_IDX = 5'(ROUNDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_STREAM,
        S_ERROR
    } state_t;

    state_t         state;
    logic           mode_q;
    logic [5:0]     round;
    logic [TW-1:0]  tcnt;
    logic [4:0]     n;
    logic [63:0]    rk_buf [ROUNDS];

    logic           accept;
    logic           capture;
    logic [4:0]     n_next;
    logic [4:0]     idx_next;

    assign accept   = ((state == S_IDLE) || (state == S_ERROR)) && start;
    // tcnt == 0 marks the first WAIT cycle, where ks_finished may still be the previous step's level
    assign capture  = (state == S_WAIT) && (tcnt != '0) && ks_finished;
    assign n_next   = n + 5'd1;
    assign idx_next = mode_q ? (LAST_IDX - n_next) : n_next;
    assign ks_round = {58'd0, round};

    always_ff @(posedge clk) begin
        if (accept)
            rk_buf[0] <= key[63:0];
        else if (capture)
            rk_buf[round[4:0] + 5'd1] <= ks_out_key[63:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            mode_q   <= 1'b0;
            round    <= '0;
            tcnt     <= '0;
            n        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            ks_start <= 1'b0;
            ks_key   <= '0;
            rk_valid <= 1'b0;
            rk_data  <= '0;
            rk_index <= '0;
            rk_last  <= 1'b0;
        end else begin
            done     <= 1'b0;
            ks_start <= 1'b0;
            case (state)
                S_IDLE, S_ERROR: begin
                    if (start) begin
                        mode_q   <= mode;
                        ks_key   <= key;
                        round    <= '0;
                        error    <= 1'b0;
                        busy     <= 1'b1;
                        ks_start <= 1'b1;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tcnt  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (capture) begin
                        ks_key <= ks_out_key;
                        round  <= round + 6'd1;
                        if ((round + 6'd1) < 6'(ROUNDS - 1)) begin
                            ks_start <= 1'b1;
                            state    <= S_ISSUE;
                        end else begin
                            // In decrypt order the first key out is the one being captured right now
                            n        <= '0;
                            rk_valid <= 1'b1;
                            rk_last  <= 1'b0;
                            rk_index <= mode_q ? LAST_IDX : 5'd0;
                            rk_data  <= mode_q ? ks_out_key[63:0] : rk_buf[0];
                            state    <= S_STREAM;
                        end
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_ERROR;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_STREAM: begin
                    if (rk_ready) begin
                        if (rk_last) begin
                            rk_valid <= 1'b0;
                            rk_last  <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            n        <= n_next;
                            rk_index <= idx_next;
                            rk_data  <= rk_buf[idx_next];
                            rk_last  <= (n_next == LAST_IDX);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
